// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised line, mid-bit sampling, one-cycle
// valid / frame-error strobes. Bit timing matches uart_tx (CLOCKS_PER_BAUD).
module uart_rx #(
  parameter int unsigned CLOCKS_PER_BAUD = 33
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  if (CLOCKS_PER_BAUD < 4) begin : g_bad_baud
    $error("uart_rx: CLOCKS_PER_BAUD must be >= 4");
  end

  localparam int unsigned CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BAUD / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          tick;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // START waits half a bit to land mid-start-bit; later states wait a whole bit.
  always_comb begin
    tick = 1'b0;
    if (state == START) tick = (baud_cnt == HALF_LAST);
    else                tick = (baud_cnt == FULL_LAST);
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (tick) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      if (tick || state == IDLE || state == BREAK) baud_cnt <= '0;
      else                                         baud_cnt <= baud_cnt + 1'b1;
      if (state == START) bit_idx <= '0;
      else if (state == DATA && tick) bit_idx <= bit_idx + 1'b1;
      if (state == DATA && tick) shift_q <= {rx_s, shift_q[7:1]};
      if (state == STOP && tick) begin
        if (rx_s) begin
          data_o  <= shift_q;
          valid_o <= 1'b1;
        end else begin
          frame_err_o <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy_o = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives 8N1 frames bit-by-bit and compares
// logged strobes against a frame-level expectation queue.
module tb_uart_rx;
  localparam int C   = 33;
  localparam int LAT = 2 + C / 2 + 9 * C + 1;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, busy_o;

  always #5 clk = ~clk;

  uart_rx #(.CLOCKS_PER_BAUD(C)) dut (
    .clk(clk), .sys_rst(sys_rst), .rx(rx), .data_o(data_o),
    .valid_o(valid_o), .frame_err_o(frame_err_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  ev_t        log_q[$];
  ev_t        exp_q[$];
  int         cyc = 0;
  int         both_cnt = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o)     log_q.push_back('{err: 1'b0, d: data_o, cyc: cyc});
    if (frame_err_o) log_q.push_back('{err: 1'b1, d: data_o, cyc: cyc});
    if (valid_o && frame_err_o) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Frame-level model: a good stop bit delivers the byte, a low stop bit
  // raises an error while data_o keeps the previous good byte.
  task automatic push_exp(input logic [7:0] b, input logic stop_ok);
    ev_t e;
    e.err = ~stop_ok;
    e.d   = stop_ok ? b : last_good;
    e.cyc = cyc;
    if (stop_ok) last_good = b;
    exp_q.push_back(e);
  endtask

  task automatic drive_line(input logic [9:0] frame, input int ncyc);
    for (int j = 0; j < ncyc; j++) begin
      rx = frame[j / C];
      @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_ok);
    push_exp(b, stop_ok);
    drive_line({stop_ok, b, 1'b0}, 10 * C);
  endtask

  task automatic drain_check(input string tag);
    int lat;
    int gap;
    repeat (2 * C) @(negedge clk);
    check({tag, " events"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check({tag, " kind"}, {31'd0, log_q[i].err}, {31'd0, exp_q[i].err});
      check({tag, " data"}, {24'd0, log_q[i].d}, {24'd0, exp_q[i].d});
      lat = log_q[i].cyc - exp_q[i].cyc;
      check({tag, " latency"}, {31'd0, (lat >= LAT - 1 && lat <= LAT + 1)}, 32'd1);
      if (i > 0 && exp_q[i].cyc - exp_q[i-1].cyc == 10 * C) begin
        gap = log_q[i].cyc - log_q[i-1].cyc;
        check({tag, " spacing"}, {31'd0, (gap >= 10 * C - 1 && gap <= 10 * C + 1)}, 32'd1);
      end
    end
    check({tag, " hold data"}, {24'd0, data_o}, {24'd0, last_good});
    check({tag, " both"}, both_cnt, 0);
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int w;
    logic [7:0] b;

    // Asynchronous reset, before any clock edge
    #2 sys_rst = 1'b1;
    #1;
    check("rst data", {24'd0, data_o}, 32'd0);
    check("rst valid", {31'd0, valid_o}, 32'd0);
    check("rst ferr", {31'd0, frame_err_o}, 32'd0);
    check("rst busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single loopback-style byte
    send(8'd24, 1'b1);
    drain_check("loop24");

    // Back-to-back at full rate, directed then random
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'hA5, 1'b1);
    send(8'h5A, 1'b1);
    drain_check("b2b");
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      send(b, 1'b1);
      repeat ($urandom_range(0, C)) @(negedge clk);
    end
    drain_check("rand");

    // Short glitch shorter than half a bit
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    check("glitch busy", {31'd0, busy_o}, 32'd1);
    w = 0;
    while (busy_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("glitch idle", {31'd0, busy_o}, 32'd0);
    drain_check("glitch");

    // Low stop bit, then a good frame
    send(8'h3C, 1'b0);
    repeat (C) @(negedge clk);
    send(8'hC3, 1'b1);
    drain_check("ferr");

    // Line held low for 20 bit times (break)
    push_exp(8'h00, 1'b0);
    rx = 1'b0;
    repeat (20 * C) @(negedge clk);
    check("break busy", {31'd0, busy_o}, 32'd1);
    rx = 1'b1;
    drain_check("break");
    check("break idle", {31'd0, busy_o}, 32'd0);
    b = 8'($urandom_range(0, 255));
    send(b, 1'b1);
    drain_check("after break");

    // Reset during bit 4 of a 0x81 frame
    drive_line({1'b1, 8'h81, 1'b0}, 5 * C + C / 2);
    rx = 1'b0;
    sys_rst = 1'b1;
    #1;
    check("midrst data", {24'd0, data_o}, 32'd0);
    check("midrst busy", {31'd0, busy_o}, 32'd0);
    check("midrst valid", {31'd0, valid_o}, 32'd0);
    last_good = 8'h00;
    rx = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    drain_check("midrst");
    send(8'h7E, 1'b1);
    drain_check("post rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
